// File: rtl/ddr_user_pkg.sv
// Shared widths and state encoding for the DDR user-port requester.
package ddr_user_pkg;
   localparam int unsigned ADDR_W = 26;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned CNT_W  = 9;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/rd_latency_pipe.sv
// Tag shift register that marks when the controller's read data for an accepted
// read arrives on user_req_dataout.
module rd_latency_pipe #(
   parameter int unsigned RD_LAT = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic tag_in,
   output logic tag_out,
   output logic busy
);

   logic [RD_LAT-1:0] stages;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         stages <= '0;
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < RD_LAT; i++) stages[i] <= stages[i-1];
      end
   end

   assign tag_out = stages[RD_LAT-1];
   assign busy    = |stages;

endmodule

// File: rtl/ddr_user_requester.sv
// Block-job initiator for the DDR controller user port: one 32-bit word per
// user_req/user_req_ack handshake, write data via a 1-entry holding register.
module ddr_user_requester
   import ddr_user_pkg::*;
#(
   parameter int unsigned ADDR_STEP = 2,
   parameter int unsigned RD_LAT    = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              job_valid,
   output logic              job_ready,
   input  logic [ADDR_W-1:0] job_addr,
   input  logic [7:0]        job_len,
   input  logic              job_we,
   output logic              job_done,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [BE_W-1:0]   wr_be,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              user_req,
   output logic              user_req_we,
   output logic [ADDR_W-1:0] user_req_address,
   output logic [BE_W-1:0]   user_req_we_array,
   output logic [DATA_W-1:0] user_req_datain,
   input  logic              user_req_ack,
   input  logic [DATA_W-1:0] user_req_dataout
);

   state_t           state, state_n;
   logic [CNT_W-1:0] count, count_n, load_left, len_cnt;
   logic             hold_full, full_n, we_n;
   logic             ack_acc, job_acc, wr_fire;
   logic             pipe_out, pipe_busy;

   assign ack_acc  = user_req & user_req_ack;
   assign job_acc  = job_valid & job_ready;
   assign len_cnt  = (job_len == 8'd0) ? CNT_W'(256) : CNT_W'(job_len);
   // holding reg may refill in the same cycle its word is acked
   assign wr_ready = (state == RUN) & user_req_we & (~hold_full | ack_acc) &
                     (load_left != CNT_W'(0));
   assign wr_fire  = wr_valid & wr_ready;

   rd_latency_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
      .CLK     (CLK),
      .RST     (RST),
      .tag_in  (ack_acc & ~user_req_we),
      .tag_out (pipe_out),
      .busy    (pipe_busy)
   );

   // next-state view, also used so user_req is registered from it
   always_comb begin
      state_n = state;
      count_n = count;
      full_n  = hold_full;
      we_n    = user_req_we;
      if (ack_acc) begin
         count_n = count - CNT_W'(1);
         full_n  = 1'b0;
      end
      if (wr_fire) full_n = 1'b1;
      case (state)
         IDLE: if (job_acc) begin
            state_n = RUN;
            we_n    = job_we;
            count_n = len_cnt;
            full_n  = 1'b0;
         end
         RUN:     if (ack_acc && count == CNT_W'(1)) state_n = user_req_we ? DONE : DRAIN;
         DRAIN:   if (rd_valid && !pipe_busy) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state             <= IDLE;
         count             <= '0;
         load_left         <= '0;
         hold_full         <= 1'b0;
         job_ready         <= 1'b1;
         job_done          <= 1'b0;
         user_req          <= 1'b0;
         user_req_we       <= 1'b0;
         user_req_address  <= '0;
         user_req_we_array <= '0;
         user_req_datain   <= '0;
         rd_data           <= '0;
         rd_valid          <= 1'b0;
      end else begin
         state       <= state_n;
         count       <= count_n;
         hold_full   <= full_n;
         user_req_we <= we_n;
         job_ready   <= (state_n == IDLE);
         job_done    <= (state_n == DONE);
         user_req    <= (state_n == RUN) && (count_n != CNT_W'(0)) && (!we_n || full_n);

         if (job_acc) begin
            user_req_address  <= job_addr;
            load_left         <= job_we ? len_cnt : CNT_W'(0);
            user_req_we_array <= job_we ? BE_W'(0) : {BE_W{1'b1}};
         end else if (ack_acc) begin
            user_req_address  <= user_req_address + ADDR_W'(ADDR_STEP);
         end

         if (wr_fire) begin
            user_req_datain   <= wr_data;
            user_req_we_array <= wr_be;
            load_left         <= load_left - CNT_W'(1);
         end

         rd_valid <= pipe_out;
         if (pipe_out) rd_data <= user_req_dataout;
      end
   end

endmodule

// File: tb/tb_ddr_user_requester.sv
// Directed bench for ddr_user_requester: job table plus reset sequences,
// with a small controller model returning address-derived read data.
module tb_ddr_user_requester;

   logic        CLK = 1'b0;
   logic        RST;
   logic        job_valid, job_ready, job_we, job_done;
   logic [25:0] job_addr;
   logic [7:0]  job_len;
   logic [31:0] wr_data, rd_data, user_req_datain, user_req_dataout;
   logic [3:0]  wr_be, user_req_we_array;
   logic        wr_valid, wr_ready, rd_valid;
   logic        user_req, user_req_we, user_req_ack;
   logic [25:0] user_req_address;

   ddr_user_requester #(.ADDR_STEP(2), .RD_LAT(4)) dut (
      .CLK(CLK), .RST(RST),
      .job_valid(job_valid), .job_ready(job_ready), .job_addr(job_addr),
      .job_len(job_len), .job_we(job_we), .job_done(job_done),
      .wr_data(wr_data), .wr_be(wr_be), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .user_req(user_req), .user_req_we(user_req_we),
      .user_req_address(user_req_address), .user_req_we_array(user_req_we_array),
      .user_req_datain(user_req_datain), .user_req_ack(user_req_ack),
      .user_req_dataout(user_req_dataout)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [25:0] addr;
      logic [7:0]  len;
      logic        we;
      logic        gap;
      int          stall_at;
      logic [25:0] exp_addr2;
      logic [25:0] exp_last;
      int          exp_acks;
   } vec_t;

   typedef struct { int due; logic [31:0] data; } rd_t;
   typedef struct { logic [31:0] data; logic [3:0] be; } wr_t;

   int  n_cmp = 0, n_fail = 0;
   rd_t exp_q[$], ctrl_q[$];
   wr_t wq[$];
   int  acks, wr_acc, last_ack_cyc, last_rdv_cyc, done_cnt, stall_cnt;
   bit  stalled, prev_hold;
   logic [25:0] exp_addr, addr2, last_addr, p_addr;
   logic [31:0] p_din;
   logic [3:0]  p_be;
   vec_t vecs[6];

   function automatic logic [31:0] rdata(input logic [25:0] a);
      return {6'h2A, a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick(input vec_t v, input bit ack_en);
      rd_t r;
      wr_t w;
      @(negedge CLK);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("rd_valid", 64'(rd_valid), 64'(1));
         chk("rd_data", 64'(rd_data), 64'(exp_q[0].data));
         void'(exp_q.pop_front());
         last_rdv_cyc = cyc;
      end else if (rd_valid) begin
         chk("rd_stray", 64'(rd_valid), 64'(0));
      end
      if (prev_hold) begin
         chk("stall_req", 64'(user_req), 64'(1));
         chk("stall_addr", 64'(user_req_address), 64'(p_addr));
         chk("stall_datain", 64'(user_req_datain), 64'(p_din));
         chk("stall_be", 64'(user_req_we_array), 64'(p_be));
      end
      if (job_done) begin
         done_cnt++;
         chk("done_once", 64'(done_cnt), 64'(1));
         chk("done_cycle", 64'(cyc), 64'((v.we ? last_ack_cyc : last_rdv_cyc) + 1));
      end
      // conflicting job offered while busy; must be ignored
      job_valid = (done_cnt == 0);
      job_addr  = 26'h2AAAAAA;
      job_len   = 8'd1;
      job_we    = ~v.we;
      user_req_ack = ack_en;
      wr_valid  = v.we && (!v.gap || (cyc % 3 == 0));
      wr_data   = 32'hC0DE_0000 + 32'(wr_acc);
      wr_be     = 4'(wr_acc) ^ 4'hA;
      if (ctrl_q.size() > 0 && ctrl_q[0].due == cyc) begin
         user_req_dataout = ctrl_q[0].data;
         void'(ctrl_q.pop_front());
      end else begin
         user_req_dataout = 32'hBAD0_0000 ^ 32'(cyc);
      end
      #1;
      if (user_req && ack_en) begin
         chk("req_addr", 64'(user_req_address), 64'(exp_addr));
         chk("req_we", 64'(user_req_we), 64'(v.we));
         if (acks == 1) addr2 = user_req_address;
         last_addr = user_req_address;
         if (v.we) begin
            if (wq.size() == 0) chk("req_bubble", 64'(user_req), 64'(0));
            else begin
               chk("req_datain", 64'(user_req_datain), 64'(wq[0].data));
               chk("req_be", 64'(user_req_we_array), 64'(wq[0].be));
               void'(wq.pop_front());
            end
         end else begin
            chk("req_be_rd", 64'(user_req_we_array), 64'(4'hF));
            r.data = rdata(user_req_address);
            r.due  = cyc + 4;
            ctrl_q.push_back(r);
            r.due  = cyc + 5;
            exp_q.push_back(r);
         end
         exp_addr = exp_addr + 26'd2;
         acks++;
         last_ack_cyc = cyc;
      end
      if (wr_valid && wr_ready) begin
         w.data = wr_data;
         w.be   = wr_be;
         wq.push_back(w);
         wr_acc++;
      end
      prev_hold = user_req && !ack_en;
      p_addr = user_req_address;
      p_din  = user_req_datain;
      p_be   = user_req_we_array;
   endtask

   task automatic start_job(input vec_t v);
      acks = 0; wr_acc = 0; done_cnt = 0; stall_cnt = 0; stalled = 0; prev_hold = 0;
      last_ack_cyc = 0; last_rdv_cyc = 0; addr2 = '0; last_addr = '0;
      exp_addr = v.addr;
      wq.delete(); exp_q.delete(); ctrl_q.delete();
      @(negedge CLK);
      chk("job_ready_idle", 64'(job_ready), 64'(1));
      job_valid = 1'b1; job_addr = v.addr; job_len = v.len; job_we = v.we;
      user_req_ack = 1'b1;
      wr_valid = 1'b0;
   endtask

   function automatic bit next_ack(input vec_t v);
      if (v.stall_at >= 0 && !stalled && acks == v.stall_at) begin
         stalled = 1; stall_cnt = 5;
      end
      if (stall_cnt > 0) begin
         stall_cnt--;
         return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic run_job(input vec_t v);
      start_job(v);
      for (int i = 0; i < 2000 && done_cnt == 0; i++) tick(v, next_ack(v));
      chk("job_done_seen", 64'(done_cnt), 64'(1));
      chk("acks", 64'(acks), 64'(v.exp_acks));
      chk("addr2", 64'(addr2), 64'(v.exp_addr2));
      chk("last_addr", 64'(last_addr), 64'(v.exp_last));
      chk("rd_outstanding", 64'(exp_q.size()), 64'(0));
      if (v.we) chk("wr_words", 64'(wr_acc), 64'(v.exp_acks));
      @(negedge CLK);
      chk("idle_ready", 64'(job_ready), 64'(1));
      chk("idle_done", 64'(job_done), 64'(0));
      chk("idle_req", 64'(user_req), 64'(0));
   endtask

   initial begin
      vec_t rv;
      vecs[0] = '{26'h100,     8'd4, 1'b1, 1'b0, -1, 26'h102,  26'h106,  4};
      vecs[1] = '{26'h40,      8'd3, 1'b0, 1'b0, -1, 26'h42,   26'h44,   3};
      vecs[2] = '{26'h200,     8'd6, 1'b1, 1'b0,  2, 26'h202,  26'h20A,  6};
      vecs[3] = '{26'h3FFFFFE, 8'd0, 1'b1, 1'b0, -1, 26'h0,    26'h1FC,  256};
      vecs[4] = '{26'h1000,    8'd5, 1'b0, 1'b0,  2, 26'h1002, 26'h1008, 5};
      vecs[5] = '{26'h300,     8'd3, 1'b1, 1'b1, -1, 26'h302,  26'h304,  3};

      RST = 1'b0; job_valid = 0; job_addr = '0; job_len = '0; job_we = 0;
      wr_data = '0; wr_be = '0; wr_valid = 0; user_req_ack = 0; user_req_dataout = '0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_user_req", 64'(user_req), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_job_done", 64'(job_done), 64'(0));
      chk("rst_job_ready", 64'(job_ready), 64'(1));
      chk("rst_wr_ready", 64'(wr_ready), 64'(0));
      chk("rst_address", 64'(user_req_address), 64'(0));
      RST = 1'b1;

      foreach (vecs[i]) run_job(vecs[i]);

      // reset while two reads are still in flight
      rv = '{26'h80, 8'd8, 1'b0, 1'b0, -1, 26'h82, 26'h8E, 8};
      start_job(rv);
      for (int i = 0; i < 20 && acks < 2; i++) tick(rv, 1'b1);
      chk("pre_rst_acks", 64'(acks), 64'(2));
      @(negedge CLK);
      RST = 1'b0; user_req_ack = 1'b0; job_valid = 1'b0; wr_valid = 1'b0;
      @(negedge CLK);
      chk("mid_rst_req", 64'(user_req), 64'(0));
      chk("mid_rst_ready", 64'(job_ready), 64'(1));
      RST = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("post_rst_rd_valid", 64'(rd_valid), 64'(0));
         chk("post_rst_req", 64'(user_req), 64'(0));
      end
      run_job(vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
